// File: rtl/rx_credit_ctl_pkg.sv
// Shared definitions for the receive-side flow-control credit logic:
// FSM encoding, FCT credit quantum and counter width.
package rx_credit_ctl_pkg;

    // Width of the credit and free-slot counters (covers depths up to 56).
    localparam int unsigned CNT_W       = 6;

    // Characters granted to the link partner by one FCT.
    localparam int unsigned FCT_QUANTUM = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_REQ  = 2'd2
    } fct_state_e;

endpackage

// File: rtl/sat_updown_ctr.sv
// Saturating up/down counter.
//   clk, reset   : clock, async active-low reset (loads RST_VAL)
//   i_up, i_dn   : increment / decrement requests; both together hold
//   o_cnt        : registered count, clamped to 0..MAX
//   o_ovf_c      : combinational, increment requested while at MAX
//   o_unf_c      : combinational, decrement requested while at 0
module sat_updown_ctr #(
    parameter int unsigned W       = 6,
    parameter int unsigned MAX     = 8,
    parameter int unsigned RST_VAL = MAX
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_up,
    input  logic         i_dn,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf_c,
    output logic         o_unf_c
);

    logic [W-1:0] r_cnt;
    logic         w_at_max;
    logic         w_at_zero;
    logic         w_inc;
    logic         w_dec;

    // Net direction after cancelling simultaneous up/down.
    always_comb begin
        w_at_max  = (r_cnt == W'(MAX));
        w_at_zero = (r_cnt == '0);
        w_inc     = i_up & ~i_dn;
        w_dec     = i_dn & ~i_up;
        o_ovf_c   = w_inc & w_at_max;
        o_unf_c   = w_dec & w_at_zero;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= W'(RST_VAL);
        end else if (w_inc && !w_at_max) begin
            r_cnt <= r_cnt + W'(1);
        end else if (w_dec && !w_at_zero) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rx_credit_ctl.sv
// Receive-side flow-control credit controller. Tracks free RX-queue slots
// and the credit extended to the link partner, and requests FCTs from the
// transmitter whenever at least one more quantum of credit can be granted.
//   clk, reset  : clock, async active-low reset
//   run_i       : link in Run; low parks the FSM in OFF and zeroes credit
//   nchar/lchar : data / link-control character strobes, char_i = code
//   pop_i       : one RX-queue slot consumed
//   fct_req_o   : registered FCT request; fct_ack_i = transmitter accepts
//   credit_o    : characters the partner may still send
//   free_o      : unoccupied RX-queue slots
//   err_o       : sticky credit/overrun error, cleared by err_clr_i
// DEPTH must be a multiple of 8 in the range 8..56.
module rx_credit_ctl
    import rx_credit_ctl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             nchar,
    input  logic             lchar,
    input  logic [7:0]       char_i,
    input  logic             pop_i,
    output logic             fct_req_o,
    input  logic             fct_ack_i,
    output logic [CNT_W-1:0] credit_o,
    output logic [CNT_W-1:0] free_o,
    output logic             err_o,
    input  logic             err_clr_i
);

    fct_state_e       r_state;
    fct_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_credit;
    logic [CNT_W-1:0] w_credit_nxt;
    logic             r_fct_req;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_dc;
    logic             w_grant;
    logic             w_room;
    logic             w_credit_unf;
    logic [CNT_W-1:0] w_free;
    logic             w_free_unf;
    logic             w_unused_free_ovf;

    // Free-slot tracking; an extra pop at full simply saturates.
    sat_updown_ctr #(
        .W   (CNT_W),
        .MAX (DEPTH)
    ) u_free_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_up    (pop_i),
        .i_dn    (w_dc),
        .o_cnt   (w_free),
        .o_ovf_c (w_unused_free_ovf),
        .o_unf_c (w_free_unf)
    );

    // Data characters plus EOP/EEP consume a queue slot; FCT/ESC do not.
    always_comb begin
        w_dc    = nchar | (lchar & ((char_i[1:0] == 2'b01) | (char_i[1:0] == 2'b10)));
        w_grant = (r_state == ST_REQ) & fct_ack_i;
        // Another quantum fits when free - credit >= quantum (widened, no wrap).
        w_room  = ({1'b0, w_free} >= ({1'b0, r_credit} + 7'(FCT_QUANTUM)));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, credit and error update.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_credit_unf = 1'b0;

        if (!run_i) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:  w_state_nxt = ST_IDLE;
                ST_IDLE: if (w_room) w_state_nxt = ST_REQ;
                ST_REQ:  if (fct_ack_i) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_OFF;
            endcase
        end

        // Credit only lives while the link runs outside OFF.
        if (!run_i || (r_state == ST_OFF)) begin
            w_credit_nxt = '0;
        end else if (w_grant && w_dc) begin
            w_credit_nxt = r_credit + CNT_W'(FCT_QUANTUM - 1);
        end else if (w_grant) begin
            w_credit_nxt = r_credit + CNT_W'(FCT_QUANTUM);
        end else if (w_dc) begin
            if (r_credit == '0) begin
                w_credit_unf = 1'b1;
            end else begin
                w_credit_nxt = r_credit - CNT_W'(1);
            end
        end

        // A fresh error outranks a clear in the same cycle.
        if (w_credit_unf || w_free_unf) begin
            w_err_nxt = 1'b1;
        end else if (err_clr_i) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // Output registers; the request flop follows the next state so it is
    // high exactly while the FSM sits in REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit  <= '0;
            r_fct_req <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_credit  <= w_credit_nxt;
            r_fct_req <= (w_state_nxt == ST_REQ);
            r_err     <= w_err_nxt;
        end
    end

    assign fct_req_o = r_fct_req;
    assign credit_o  = r_credit;
    assign free_o    = w_free;
    assign err_o     = r_err;

endmodule

// File: tb/tb_rx_credit_ctl.sv
// Bench for rx_credit_ctl: a DEPTH=8 and a DEPTH=16 instance driven from a
// vector table; expected outputs are queued at drive time and compared
// one clock later, followed by hand-written reset sequences.
module tb_rx_credit_ctl;

    typedef struct {
        bit         dut;
        bit         run;
        bit         nchar;
        bit         lchar;
        logic [7:0] chr;
        bit         pop;
        bit         ack;
        bit         clr;
        bit         ereq;
        int         ecred;
        int         efree;
        bit         eerr;
    } vec_t;

    typedef struct {
        int idx;
        bit dut;
        bit req;
        int cred;
        int free;
        bit err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] run, nchar, lchar, pop, ack, clr;
    logic [7:0] chr    [2];
    logic [1:0] req, err;
    logic [5:0] credit [2];
    logic [5:0] free   [2];

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    rx_credit_ctl #(.DEPTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .run_i     (run[0]),
        .nchar     (nchar[0]),
        .lchar     (lchar[0]),
        .char_i    (chr[0]),
        .pop_i     (pop[0]),
        .fct_req_o (req[0]),
        .fct_ack_i (ack[0]),
        .credit_o  (credit[0]),
        .free_o    (free[0]),
        .err_o     (err[0]),
        .err_clr_i (clr[0])
    );

    rx_credit_ctl #(.DEPTH(16)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .run_i     (run[1]),
        .nchar     (nchar[1]),
        .lchar     (lchar[1]),
        .char_i    (chr[1]),
        .pop_i     (pop[1]),
        .fct_req_o (req[1]),
        .fct_ack_i (ack[1]),
        .credit_o  (credit[1]),
        .free_o    (free[1]),
        .err_o     (err[1]),
        .err_clr_i (clr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int idx, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0d, expected %0d", name, idx, act, expv);
        end
    endfunction

    function automatic void add(input bit d, input bit r, input bit nc, input bit lc,
                                input logic [7:0] c, input bit p, input bit a, input bit cl,
                                input bit erq, input int ecr, input int efr, input bit eer);
        vec_t v;
        v.dut = d; v.run = r; v.nchar = nc; v.lchar = lc; v.chr = c;
        v.pop = p; v.ack = a; v.clr = cl;
        v.ereq = erq; v.ecred = ecr; v.efree = efr; v.eerr = eer;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        run = '0; nchar = '0; lchar = '0; pop = '0; ack = '0; clr = '0;
        chr[0] = 8'h00; chr[1] = 8'h00;
        run[v.dut]   = v.run;
        nchar[v.dut] = v.nchar;
        lchar[v.dut] = v.lchar;
        chr[v.dut]   = v.chr;
        pop[v.dut]   = v.pop;
        ack[v.dut]   = v.ack;
        clr[v.dut]   = v.clr;
    endtask

    // Scoreboard consumer: each queued expectation is due one edge after drive.
    initial begin : sb_check
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("fct_req_o", e.idx, int'(req[e.dut]), int'(e.req));
                check("credit_o",  e.idx, int'(credit[e.dut]), e.cred);
                check("free_o",    e.idx, int'(free[e.dut]), e.free);
                check("err_o",     e.idx, int'(err[e.dut]), int'(e.err));
            end
        end
    end

    initial begin : drive
        exp_t e;
        int   guard;
        n_tests = 0;
        n_fail  = 0;
        run = '0; nchar = '0; lchar = '0; pop = '0; ack = '0; clr = '0;
        chr[0] = 8'h00; chr[1] = 8'h00;
        reset = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req8",  -1, int'(req[0]), 0);
        check("rst_cred8", -1, int'(credit[0]), 0);
        check("rst_free8", -1, int'(free[0]), 8);
        check("rst_err8",  -1, int'(err[0]), 0);
        check("rst_free16", -1, int'(free[1]), 16);
        check("rst_cred16", -1, int'(credit[1]), 0);
        @(negedge clk);
        reset = 1'b1;

        // DEPTH=16: two FCTs from empty, drain to credit 5, run drop, +7 on grant+dc.
        add(1, 1,0,0,8'h00,0,0,0, 0, 0,16,0);
        add(1, 1,0,0,8'h00,0,0,0, 1, 0,16,0);
        add(1, 1,0,0,8'h00,0,1,0, 0, 8,16,0);
        add(1, 1,0,0,8'h00,0,0,0, 1, 8,16,0);
        add(1, 1,0,0,8'h00,0,1,0, 0,16,16,0);
        add(1, 1,0,0,8'h00,0,0,0, 0,16,16,0);
        for (int k = 1; k <= 11; k++) add(1, 1,1,0,8'h00,0,0,0, 0, 16-k, 16-k, 0);
        add(1, 0,0,0,8'h00,0,0,0, 0, 0, 5,0);
        add(1, 1,0,0,8'h00,0,0,0, 0, 0, 5,0);
        add(1, 1,0,0,8'h00,1,0,0, 0, 0, 6,0);
        add(1, 1,0,0,8'h00,1,0,0, 0, 0, 7,0);
        add(1, 1,0,0,8'h00,1,0,0, 0, 0, 8,0);
        add(1, 1,0,0,8'h00,0,0,0, 1, 0, 8,0);
        add(1, 1,1,0,8'h00,0,1,0, 0, 7, 7,0);
        add(1, 1,0,0,8'h00,0,0,0, 0, 7, 7,0);

        // DEPTH=8: first FCT, lchar decoding, drain and overrun, sticky error.
        add(0, 1,0,0,8'h00,0,0,0, 0, 0, 8,0);
        add(0, 1,0,0,8'h00,0,0,0, 1, 0, 8,0);
        add(0, 1,0,0,8'h00,0,0,0, 1, 0, 8,0);
        add(0, 1,0,0,8'h00,0,1,0, 0, 8, 8,0);
        add(0, 1,0,0,8'h00,0,0,0, 0, 8, 8,0);
        add(0, 1,0,1,8'h00,0,0,0, 0, 8, 8,0);
        add(0, 1,0,1,8'hFF,0,0,0, 0, 8, 8,0);
        add(0, 1,0,1,8'h01,0,0,0, 0, 7, 7,0);
        add(0, 1,0,1,8'h02,0,0,0, 0, 6, 6,0);
        for (int k = 1; k <= 6; k++) add(0, 1,1,0,8'h00,0,0,0, 0, 6-k, 6-k, 0);
        add(0, 1,1,0,8'h00,0,0,0, 0, 0, 0,1);
        add(0, 1,0,0,8'h00,0,0,0, 0, 0, 0,1);
        add(0, 1,0,0,8'h00,0,0,1, 0, 0, 0,0);
        add(0, 1,1,0,8'h00,0,0,1, 0, 0, 0,1);
        add(0, 1,0,0,8'h00,0,0,1, 0, 0, 0,0);
        for (int k = 1; k <= 8; k++) add(0, 1,0,0,8'h00,1,0,0, 0, 0, k, 0);
        add(0, 1,0,0,8'h00,1,0,0, 1, 0, 8,0);
        add(0, 1,1,0,8'h00,0,1,0, 0, 7, 7,0);
        add(0, 0,0,0,8'h00,0,0,0, 0, 0, 7,0);
        add(0, 1,0,0,8'h00,0,0,0, 0, 0, 7,0);
        add(0, 1,0,0,8'h00,0,0,0, 0, 0, 7,0);
        add(0, 1,0,0,8'h00,1,0,0, 0, 0, 8,0);
        add(0, 1,0,0,8'h00,0,0,0, 1, 0, 8,0);
        add(0, 1,0,0,8'h00,0,0,0, 1, 0, 8,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            e.idx = i; e.dut = vecs[i].dut; e.req = vecs[i].ereq;
            e.cred = vecs[i].ecred; e.free = vecs[i].efree; e.err = vecs[i].eerr;
            sb.push_back(e);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("sb_drained", -1, sb.size(), 0);

        // Reset while a request is pending: outputs drop without a clock edge.
        @(negedge clk);
        check("pre_rst_req", -1, int'(req[0]), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_req8",   -1, int'(req[0]), 0);
        check("async_cred8",  -1, int'(credit[0]), 0);
        check("async_free8",  -1, int'(free[0]), 8);
        check("async_err8",   -1, int'(err[0]), 0);
        check("async_free16", -1, int'(free[1]), 16);

        // After release the FSM restarts from OFF without waiting for an ack.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req_e1", -1, int'(req[0]), 0);
        @(posedge clk);
        #1;
        check("post_rst_req_e2", -1, int'(req[0]), 1);
        check("post_rst_cred",   -1, int'(credit[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_credit_ctl.md
RX_CREDIT_CTL -- requirements
Module: rx_credit_ctl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: receive-queue depth in characters; multiple of 8, range 8..56.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port run_i  input  1  link in Run state; low clears credit and parks FSM in OFF.
REQ-005 The block SHALL have port nchar  input  1  data character received this cycle (same strobe that writes the RX queue).
REQ-006 The block SHALL have port lchar  input  1  link-control character received this cycle.
REQ-007 The block SHALL have port char_i  input  8  character code accompanying nchar/lchar.
REQ-008 The block SHALL have port pop_i  input  1  one RX-queue slot consumed this cycle (queue ack_o).
REQ-009 The block SHALL have port fct_req_o  output  1  request to transmitter to send one FCT.
REQ-010 The block SHALL have port fct_ack_i  input  1  transmitter accepted FCT request this cycle.
REQ-011 The block SHALL have port credit_o  output  6  characters the link partner may still send.
REQ-012 The block SHALL have port free_o  output  6  unoccupied RX-queue slots.
REQ-013 The block SHALL have port err_o  output  1  sticky credit/overrun error.
REQ-014 The block SHALL have port err_clr_i  input  1  clears err_o.

Function
REQ-015 The block SHALL treat a cycle as a data-character cycle (dc) when nchar=1, or lchar=1 with char_i[1:0] = 01 or 10 (EOP/EEP); all other lchar codes (FCT, ESC) SHALL NOT count.
REQ-016 free SHALL be decremented on dc alone, incremented on pop_i alone, and held on dc and pop_i together or neither.
REQ-017 free SHALL NOT wrap: dc with free=0 and pop_i=0 SHALL hold free at 0 and set err_o; pop_i with free=DEPTH SHALL hold free at DEPTH.
REQ-018 credit SHALL change by +8 on FCT grant (REQ state and fct_ack_i=1), -1 on dc, and +7 on both in one cycle.
REQ-019 dc with credit=0 and no simultaneous grant SHALL set err_o and leave credit at 0.
REQ-020 err_o SHALL remain set until a cycle with err_clr_i=1 and no new error; a new error in the same cycle as err_clr_i SHALL win.
REQ-021 The FSM SHALL have states OFF, IDLE, REQ; fct_req_o SHALL be 1 only in REQ and SHALL be registered.
REQ-022 Transitions SHALL be: OFF->IDLE when run_i=1; IDLE->REQ when run_i=1 and free-credit >= 8; REQ->IDLE on fct_ack_i=1; any state->OFF when run_i=0.
REQ-023 Entering or residing in OFF SHALL clear credit to 0 next edge; free SHALL be unaffected by run_i.
REQ-024 fct_req_o SHALL deassert on the edge after fct_ack_i and stay low at least one cycle before the next request.
REQ-025 credit_o and free_o SHALL reflect registered values updated on the same edge as the causing event.
REQ-026 Invariant credit <= free SHALL hold whenever err_o has not been set.

Reset
REQ-027 Reset assertion SHALL asynchronously force FSM=OFF, credit_o=0, free_o=DEPTH, fct_req_o=0, err_o=0.
REQ-028 Reset deassertion mid-handshake SHALL NOT require fct_ack_i to complete; a pending grant is discarded.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the FCT credit quantum (8), and the 6-bit counter width.
REQ-030 One sub-module, sat_updown_ctr (saturating up/down counter with overflow/underflow flags), SHALL be used for free; credit SHALL be inline.

Verification
REQ-031 Reset, run_i=1, DEPTH=8, no traffic -> fct_req_o=1 two edges after run_i; ack -> credit_o=8, fct_req_o=0, no second request while free_o=8.
REQ-032 After grant, 8 nchar cycles -> credit_o 8..0, free_o 8..0; ninth nchar -> err_o=1, free_o=0, credit_o=0.
REQ-033 lchar with char_i=00 (FCT) and FF -> no count change; char_i 01/10 -> free_o and credit_o each -1.
REQ-034 DEPTH=16, queue empty -> two FCTs in sequence, credit_o=16; dc and fct_ack_i same cycle -> +7 observed.
REQ-035 Credit outstanding 5, run_i dropped one cycle -> credit_o=0, FSM OFF, free_o unchanged; run_i high -> new FCT only when free-credit >= 8.
REQ-036 Reset asserted while fct_req_o=1 -> immediate fct_req_o=0, all outputs at REQ-027 values without clock.
